// File: rtl/bus_arbiter16_if.sv
// Purpose : shared-bus request/grant bundle between the requesting units and bus_arbiter16.
// Latency : n/a (signal bundle only).
// Backpr. : req is a level held until the requester is served; done releases the bus.
//
// Signals:
//   req[15:0]        requests, one per unit (level)
//   done             current owner releases the bus
//   grant[15:0]      registered one-hot grant, zero when idle
//   grant_index[3:0] encoded grant, 0 when idle
//   grant_valid      grant is non-zero
//   timeout          one-cycle pulse on a forced release
interface bus_arbiter16_if;
   logic [15:0] req;
   logic        done;
   logic [15:0] grant;
   logic [3:0]  grant_index;
   logic        grant_valid;
   logic        timeout;

   // requester side
   modport master (
      output req, done,
      input  grant, grant_index, grant_valid, timeout
   );

   // arbiter side
   modport slave (
      input  req, done,
      output grant, grant_index, grant_valid, timeout
   );
endinterface

// File: rtl/bus_arbiter16.sv
// Purpose : 16-way round-robin bus arbiter with registered one-hot grant and encoded index.
// Latency : 1 cycle req->grant; one idle turnaround cycle between any two grants.
// Backpr. : owner keeps the bus until done or its req drops; other requests wait, never preempt.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    synchronous active-low reset
//   bus        bus_arbiter16_if.slave (req, done in; grant, grant_index, grant_valid, timeout out)
// Parameters:
//   TIMEOUT_CYCLES  max GRANT cycles per owner when ARB_TIMEOUT_EN is defined (2..256)
// Build option:
//   ARB_TIMEOUT_EN  defined -> hold counter forces release and pulses timeout;
//                   undefined -> owner holds indefinitely, timeout tied 0.

// 16-to-4 one-hot encoder; an all-zero input encodes to 0.
module onehot_enc16 (
   input  logic [15:0] onehot,
   output logic [3:0]  index
);
   always_comb begin
      index = '0;
      for (int i = 0; i < 16; i++) begin
         if (onehot[i]) index = index | 4'(i);
      end
   end
endmodule

module bus_arbiter16 #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic           clk,
   input  logic           reset_n,
   bus_arbiter16_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [15:0] grant_q, grant_nxt;
   logic [3:0]  last_owner, last_nxt;
   logic        timeout_q, timeout_nxt;
   logic [3:0]  winner, cand;
   logic        found;
   logic        release_c;
   logic        expired;
   logic [3:0]  enc_index;

   // Round-robin scan: start just above last_owner and wrap; the 16th
   // candidate is last_owner itself, so a lone requester wins again.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 1; i <= 16; i++) begin
         cand = last_owner + 4'(i);
         if (!found && bus.req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // During GRANT last_owner is the current owner.
   assign release_c = bus.done | ~bus.req[last_owner];

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] hold_cnt;

   // Held at zero while idle, so the first GRANT cycle sees 0 and the
   // TIMEOUT_CYCLES-th GRANT cycle sees TIMEOUT_CYCLES-1.
   always_ff @(posedge clk) begin
      if (!reset_n)           hold_cnt <= '0;
      else if (state == IDLE) hold_cnt <= '0;
      else                    hold_cnt <= hold_cnt + CW'(1);
   end

   assign expired = (hold_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign expired = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_q;
      last_nxt    = last_owner;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt = 16'(1) << winner;
               last_nxt  = winner;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // A normal release wins over a forced one in the same cycle.
            if (release_c || expired) begin
               grant_nxt   = '0;
               state_nxt   = IDLE;
               timeout_nxt = expired & ~release_c;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant_q    <= '0;
         last_owner <= 4'hF;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         last_owner <= last_nxt;
         timeout_q  <= timeout_nxt;
      end
   end

   onehot_enc16 u_enc (
      .onehot (grant_q),
      .index  (enc_index)
   );

   assign bus.grant       = grant_q;
   assign bus.grant_index = enc_index;
   assign bus.grant_valid = |grant_q;
   assign bus.timeout     = timeout_q;
endmodule
